// File: rtl/divider_iter_if.sv
// Handshake and data bundle between the execute stage and the divider.
// The master side issues requests; the slave side is the divider itself.
interface divider_iter_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               sign;
   logic               abort;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [2*WIDTH-1:0] result;
   logic               busy;

   modport master (
      output start, sign, abort, A, B,
      input  result, busy
   );

   modport slave (
      input  start, sign, abort, A, B,
      output result, busy
   );
endinterface

// File: rtl/divider_iter.sv
// Iterative radix-2 non-restoring divider for DIV/DIVU.
// result = {remainder, quotient}; busy stalls the pipeline.
module divider_iter #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           resetn,
   divider_iter_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic               mode_s;
   logic               a_neg;
   logic               b_neg;
   logic               b_zero;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   bm;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;
   logic [2*WIDTH-1:0] res_q;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_nx;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   q_fx;
   logic [WIDTH-1:0]   r_fx;

   always_comb begin
      a_mag = (bus.sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      b_mag = (bus.sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;
   end

   // Wraps modulo 2^(WIDTH+1); the post-add value is always in range.
   always_comb begin
      rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
      if (rem[WIDTH])
         rem_nx = rem_sh + {1'b0, bm};
      else
         rem_nx = rem_sh - {1'b0, bm};
   end

   always_comb begin
      r_mag = rem[WIDTH-1:0] + (rem[WIDTH] ? bm : '0);
      q_fx  = (mode_s && (a_neg ^ b_neg)) ? -quo : quo;
      r_fx  = (mode_s && a_neg) ? -r_mag : r_mag;
      if (b_zero) begin
         q_fx = '1;
         r_fx = a_raw;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         count  <= '0;
         mode_s <= 1'b0;
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         b_zero <= 1'b0;
         a_raw  <= '0;
         bm     <= '0;
         rem    <= '0;
         quo    <= '0;
         res_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  mode_s <= bus.sign;
                  a_neg  <= bus.sign & bus.A[WIDTH-1];
                  b_neg  <= bus.sign & bus.B[WIDTH-1];
                  b_zero <= (bus.B == '0);
                  a_raw  <= bus.A;
                  bm     <= b_mag;
                  quo    <= a_mag;
                  rem    <= '0;
                  count  <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  rem   <= rem_nx;
                  quo   <= {quo[WIDTH-2:0], ~rem_nx[WIDTH]};
                  count <= count + 1'b1;
                  if (count == CW'(WIDTH-1))
                     state <= FIX;
               end
            end
            FIX: begin
               if (!bus.abort)
                  res_q <= {r_fx, q_fx};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Combinational in the start cycle so the stall is immediate.
   assign bus.busy   = (state != IDLE) ||
                       (bus.start && !bus.abort);
   assign bus.result = res_q;

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed table,
// corner sequences and random operands against an arithmetic model.
module tb_divider_iter;

   logic clk;
   logic resetn;
   int   errs;
   int   checks;
   logic [63:0] last_res;

   divider_iter_if #(.WIDTH(32)) bus ();

   divider_iter #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [63:0] model(bit s, logic [31:0] a,
                                         logic [31:0] b);
      int sa;
      int sb;
      int q;
      int r;
      if (b == 32'd0)
         return {a, 32'hFFFFFFFF};
      if (!s)
         return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF)
         return {32'h0, 32'h80000000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
   endfunction

   task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chkn(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Called on a negedge in IDLE; returns on the negedge where busy drops.
   task automatic run_div(bit s, logic [31:0] a, logic [31:0] b,
                          logic [63:0] exp, string nm);
      int n;
      bus.sign  = s;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      #1;
      chk1({nm, "-busy0"}, bus.busy, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      n = 1;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chkn({nm, "-cycles"}, n, 34);
      chk64({nm, "-result"}, bus.result, exp);
      last_res = exp;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit          rs;

      errs      = 0;
      checks    = 0;
      last_res  = '0;
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.sign  = 1'b0;
      bus.abort = 1'b0;
      bus.A     = '0;
      bus.B     = '0;

      vecs[0] = '{0, 32'd100,        32'd7,        64'h00000002_0000000E};
      vecs[1] = '{1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
      vecs[2] = '{1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
      vecs[3] = '{0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000};
      vecs[4] = '{0, 32'd5,          32'd0,        64'h00000005_FFFFFFFF};
      vecs[5] = '{1, 32'hFFFFFFFB,   32'd0,        64'hFFFFFFFB_FFFFFFFF};
      vecs[6] = '{1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      vecs[7] = '{0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
      vecs[8] = '{1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
      vecs[9] = '{0, 32'd3,          32'd10,       64'h00000003_00000000};

      repeat (2) @(negedge clk);
      chk1("rst-busy", bus.busy, 1'b0);
      chk64("rst-result", bus.result, 64'h0);
      resetn = 1'b1;
      @(negedge clk);
      chk1("idle-busy", bus.busy, 1'b0);

      // Directed table, issued back-to-back.
      for (int i = 0; i < 10; i++)
         run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp,
                 $sformatf("vec%0d", i));

      // start while in CALC is ignored.
      bus.sign  = 1'b0;
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.A     = 32'd1;
      bus.B     = 32'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      begin
         int n;
         n = 7;
         while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
         end
         chkn("ignore-cycles", n, 34);
      end
      chk64("ignore-result", bus.result, 64'h00000002_0000000E);
      last_res = 64'h00000002_0000000E;

      // Abort in CALC cycle 10 with a simultaneous start.
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.A     = 32'd1;
      bus.B     = 32'd1;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      #1;
      chk1("abort-busy-now", bus.busy, 1'b1);
      @(negedge clk);
      chk1("abort-busy-next", bus.busy, 1'b0);
      chk64("abort-result", bus.result, last_res);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      chk1("abort-nolatch", bus.busy, 1'b0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "post-abort");

      // Asynchronous reset in the middle of CALC.
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk1("arst-busy", bus.busy, 1'b0);
      chk64("arst-result", bus.result, 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7),
              "post-rst");

      // Random operands, back-to-back.
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         ra = $urandom;
         case ($urandom % 4)
            0: rb = 32'($signed($urandom_range(0, 6)) - 3);
            1: rb = $urandom & 32'h0000FFFF;
            2: rb = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0,
                     16'($urandom)};
            default: rb = $urandom;
         endcase
         if (i % 10 == 3)
            ra = 32'h80000000;
         run_div(rs, ra, rb, model(rs, ra, rb),
                 $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

endmodule
